note_rom_arbiter: RTL and testbench
===================================

Name: note_rom_arbiter

Overview:
- Shares the single synchronous note-letter glyph ROM (8-bit pixel codes) among several sprite renderers in the display pipeline. Each renderer computes its own ROM address from hcount/vcount and its sprite origin.
- One address is issued to the ROM per pixel_clk. Read data returns tagged with the requester ID after a fixed pipeline latency.
- Sits between the sprite renderers and the ROM instance, all on pixel_clk.

Parameters:
- NUM_REQ, 4: number of requesters (1..8).
- ADDR_W, 16: ROM address width.
- DATA_W, 8: ROM data width.
- ROM_LAT, 1: ROM read latency in cycles, from registered address to valid data (1..3).
- localparam ID_W: clog2(NUM_REQ), minimum 1.

Ports:
- pixel_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- sync_clr  in  1  synchronous pulse at frame start (vsync); resets the arbitration pointer.
- req  in  NUM_REQ  per-requester read request, level.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- rom_addr  out  ADDR_W  registered address to the ROM.
- rom_data  in  DATA_W  ROM read data.
- rsp_valid  out  1  response strobe.
- rsp_id  out  ID_W  requester index of the response.
- rsp_data  out  DATA_W  returned ROM word.
- busy  out  1  high if any read is in flight.

Behaviour:
- Clock and reset: already decided — one clock, pixel_clk; reset is asynchronous and active-low on reset_n.
- Reset values: rom_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, pointer=0, all pipeline valids=0. gnt is forced to 0 while reset_n=0.
- Acceptance: a transfer occurs in cycle t when req[i] & gnt[i]. At most one gnt bit is set per cycle. gnt is 0 when req=0.
- Grant selection (round-robin): search starts at the pointer, ascending and wrapping modulo NUM_REQ. The first asserted req wins. After an accept from i, pointer <= (i+1) mod NUM_REQ. Without an accept, the pointer holds.
- Non-granted requesters must hold req and req_addr stable until granted. The arbiter does not queue requests.
- Pipeline:
  - edge end of t: rom_addr <= req_addr[i] and stage0 {valid, id} <= {1, i}.
  - A shift chain of ROM_LAT stages carries valid/id alongside the ROM.
  - At the edge ending cycle t+ROM_LAT, rsp_valid, rsp_id and rsp_data <= rom_data are registered.
  - Total latency from accept to rsp_valid is ROM_LAT+1 cycles, e.g. 2 for ROM_LAT=1.
- Throughput: one accept per cycle. Back-to-back responses appear on consecutive cycles with no bubbles. rsp_valid is a single-cycle pulse per accept.
- No response backpressure: consumers must sample rsp_* on rsp_valid.
- rom_addr holds its last value when there is no accept. It is not zeroed.
- busy = OR of all stage valids plus the output valid.
- sync_clr: pointer <= 0 at the next edge, overriding the accept-based update.
  - Grant selection in the sync_clr cycle itself still uses the old pointer.
  - In-flight reads complete normally.
- Reset mid-operation: all in-flight reads are discarded, with no rsp_valid for them. Operation restarts from pointer 0.
- NUM_REQ=1: always grant 0 when req[0]=1; rsp_id is always 0.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer register is removed and sync_clr is ignored.
- Undefined: round-robin as above.
- Latency and response behaviour are identical in both modes.

Decomposition:
- Shared package notes_pkg:
  - localparams NOTE_ROM_ADDR_W=16 and NOTE_ROM_DATA_W=8;
  - function clog2;
  - typedef for the rsp bundle {valid, id, data}.
- One natural sub-module: rr_pick, a combinational rotate/priority-encode from (req, pointer) to one-hot gnt plus index. It is instantiated once and swapped for a plain priority encoder under ARB_FIXED_PRIO_EN.

Test Plan:
- Reset then single request: reset_n low then high; req=4'b0010, addr1=16'h0123 for one cycle -> gnt=4'b0010 the same cycle; rom_addr=16'h0123 next cycle; rsp_valid=1, rsp_id=1, rsp_data=ROM[0x123] two cycles after the accept.
- Round-robin fairness: req=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 consecutive rsp_valid pulses with matching ids and no bubbles.
- Pointer wrap with sparse requests: pointer=3 after granting 2; req=4'b0101 -> grant 0, then 2, then 0.
- sync_clr: after granting 1, pulse sync_clr with req=4'b1111 -> that cycle grants 2, then the following cycle grants 0.
- Mid-flight reset: accept two reads, assert reset_n low for one cycle before any response -> no rsp_valid, busy=0, rom_addr=0; next req=4'b1000 grants 3 from pointer 0.
- ARB_FIXED_PRIO_EN build: req=4'b1110 held 3 cycles -> grant 1 every cycle; req 2 and req 3 starve as specified.

Source files
------------

// File: rtl/notes_pkg.sv
// Shared definitions for the note-letter glyph ROM path: default widths,
// a width helper and the response bundle carried out of the arbiter.
package notes_pkg;

  localparam int NOTE_ROM_ADDR_W = 16;
  localparam int NOTE_ROM_DATA_W = 8;

  // Wide enough to hold the index of up to eight requesters.
  localparam int RSP_ID_W = 3;

  // Ceiling log2 that never returns less than 1, so one-requester builds
  // still get a legal one-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef struct packed {
    logic                       valid;
    logic [RSP_ID_W-1:0]        id;
    logic [NOTE_ROM_DATA_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational grant picker. Round-robin from ptr by default; with
// ARB_FIXED_PRIO_EN defined it becomes a plain lowest-index-wins encoder.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

`ifdef ARB_FIXED_PRIO_EN

  logic [ID_W-1:0] unused_ptr;
  assign unused_ptr = ptr;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = ID_W'(i);
        any    = 1'b1;
      end
    end
  end

`else

  // Rotate the requests so position 0 is the pointer, take the lowest set
  // bit, then map the rotated position back to a requester index.
  logic [2*NUM_REQ-1:0] doubled;
  logic [2*NUM_REQ-1:0] rotated;
  int                   hit;

  assign doubled = {req, req};
  assign rotated = doubled >> ptr;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    hit = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        hit = int'(ptr) + j;
        any = 1'b1;
      end
    end
    if (hit >= NUM_REQ) hit = hit - NUM_REQ;
    if (any) begin
      idx = ID_W'(hit);
      gnt = NUM_REQ'(1) << hit;
    end
  end

`endif

endmodule

// File: rtl/note_rom_arbiter.sv
// Shares one synchronous glyph ROM among sprite renderers, one read per
// pixel_clk, tagging returned data with the requester id. Build with
// ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module note_rom_arbiter
  import notes_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  ADDR_W  = NOTE_ROM_ADDR_W,
  parameter int  DATA_W  = NOTE_ROM_DATA_W,
  parameter int  ROM_LAT = 1,
  localparam int ID_W    = clog2(NUM_REQ)
) (
  input  logic                      pixel_clk,
  input  logic                      reset_n,
  input  logic                      sync_clr,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) pick_i (
    .req(req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign gnt    = reset_n ? pick_gnt : '0;
  assign accept = pick_any & reset_n;

`ifdef ARB_FIXED_PRIO_EN

  logic unused_sync_clr;
  assign unused_sync_clr = sync_clr;
  assign ptr             = '0;

`else

  // sync_clr wins over the accept update; the grant in that same cycle
  // was already made from the old pointer.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (sync_clr) begin
      ptr <= '0;
    end else if (accept) begin
      if (pick_idx == ID_W'(NUM_REQ - 1)) ptr <= '0;
      else                                ptr <= pick_idx + 1'b1;
    end
  end

`endif

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // rom_addr deliberately holds between accepts rather than returning to 0.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
    end else if (accept) begin
      rom_addr <= sel_addr;
    end
  end

  logic [ROM_LAT-1:0] stage_valid;
  logic [ID_W-1:0]    stage_id [ROM_LAT];

  // valid/id ride alongside the ROM so the tag lines up with its data.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= '0;
      for (int k = 0; k < ROM_LAT; k++) stage_id[k] <= '0;
    end else begin
      stage_valid[0] <= accept;
      stage_id[0]    <= pick_idx;
      for (int k = 1; k < ROM_LAT; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_id[k]    <= stage_id[k-1];
      end
    end
  end

  rsp_t rsp_q;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q.valid <= stage_valid[ROM_LAT-1];
      if (stage_valid[ROM_LAT-1]) begin
        rsp_q.id   <= RSP_ID_W'(stage_id[ROM_LAT-1]);
        rsp_q.data <= rom_data;
      end
    end
  end

  assign rsp_valid = rsp_q.valid;
  assign rsp_id    = rsp_q.id[ID_W-1:0];
  assign rsp_data  = rsp_q.data;
  assign busy      = (|stage_valid) | rsp_q.valid;

endmodule

// File: tb/tb_note_rom_arbiter.sv
// Scoreboard bench for note_rom_arbiter: directed scenarios then random
// traffic against a queue-based reference model (honours ARB_FIXED_PRIO_EN).
module tb_note_rom_arbiter;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 1;

  logic            pixel_clk = 1'b0;
  logic            reset_n   = 1'b0;
  logic            sync_clr  = 1'b0;
  logic [N-1:0]    req       = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  note_rom_arbiter #(
    .NUM_REQ(N),
    .ADDR_W (AW),
    .DATA_W (DW),
    .ROM_LAT(LAT)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset_n  (reset_n),
    .sync_clr (sync_clr),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [7:0] rom_func(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  // Glyph ROM stand-in: data follows the registered address directly.
  assign rom_data = rom_func(rom_addr);

  typedef struct {
    int         id;
    logic [7:0] data;
    int         acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          model_ptr = 0;
  logic [15:0] exp_rom_addr = '0;
  logic [15:0] addr_tab [N];
  logic [N-1:0] pend;

  always @(posedge pixel_clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference rule: first asserted request scanning upward from the pointer.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    int start;
`ifdef ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int off = 0; off < N; off++) begin
      int k;
      k = (start + off) % N;
      if (((r >> k) & 1) != 0) return k;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] r, input logic sc, output int win);
    logic [N-1:0] expg;
    req      = r;
    sync_clr = sc;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_tab[i];
    @(negedge pixel_clk);
    check("rom_addr", rom_addr, exp_rom_addr);
    win  = model_pick(r, model_ptr);
    expg = (win >= 0) ? N'(1) << win : '0;
    check("gnt", gnt, expg);
    if (win >= 0) begin
      sb.push_back('{win, rom_func(addr_tab[win]), cyc});
      exp_rom_addr = addr_tab[win];
      model_ptr    = (win + 1) % N;
    end
`ifndef ARB_FIXED_PRIO_EN
    if (sc) model_ptr = 0;
`endif
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    sync_clr = 1'b0;
    req      = '1;
    #1;
    sb.delete();
    model_ptr    = 0;
    exp_rom_addr = '0;
    check("gnt_in_reset", gnt, 0);
    check("busy_in_reset", busy, 0);
    check("rsp_valid_in_reset", rsp_valid, 0);
    check("rom_addr_in_reset", rom_addr, 0);
    check("rsp_id_in_reset", rsp_id, 0);
    check("rsp_data_in_reset", rsp_data, 0);
    req = '0;
    @(posedge pixel_clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge pixel_clk) begin
    int   inflight;
    exp_t e;
    #2;
    if (reset_n) begin
      inflight = 0;
      foreach (sb[j]) if (sb[j].acc < cyc) inflight++;
      check("busy", busy, (inflight > 0) ? 1 : 0);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_latency", cyc - e.acc, LAT + 1);
        end
      end else if (sb.size() > 0 && sb[0].acc + LAT + 1 <= cyc) begin
        check("rsp_missing", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int win;
    for (int i = 0; i < N; i++) addr_tab[i] = 16'h1000 * (i + 1) + 16'h0010 * i;
    do_reset();

    addr_tab[1] = 16'h0123;
    applyStimulus(4'b0010, 1'b0, win);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b0, win);

    applyStimulus(4'b0000, 1'b1, win);
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, 1'b0, win);

    applyStimulus(4'b0100, 1'b0, win);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0101, 1'b0, win);

    applyStimulus(4'b0010, 1'b0, win);
    applyStimulus(4'b1111, 1'b1, win);
    applyStimulus(4'b1111, 1'b0, win);

    for (int i = 0; i < 3; i++) applyStimulus(4'b1110, 1'b0, win);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b0, win);

    addr_tab[3] = 16'hBEEF;
    applyStimulus(4'b1111, 1'b0, win);
    applyStimulus(4'b1111, 1'b0, win);
    do_reset();
    applyStimulus(4'b1000, 1'b0, win);
    applyStimulus(4'b0011, 1'b0, win);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b0, win);

    // Random traffic: requests are levels that hold until granted.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 6) begin
          pend[i]     = 1'b1;
          addr_tab[i] = 16'($urandom);
        end
      end
      applyStimulus(pend, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, win);
      if (win >= 0) pend[win] = 1'b0;
    end

    for (int i = 0; i < 6; i++) applyStimulus(4'b0000, 1'b0, win);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
